// File: rtl/uart_rx_mon_pkg.sv
// rtl/uart_rx_mon_pkg.sv - shared types, parity modes and counter sizing for uart_rx_mon
package uart_rx_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int cnt_width(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_rx_mon_fifo.sv
// rtl/uart_rx_mon_fifo.sv - synchronous FIFO with full/empty flags and a combinational head read
module uart_rx_mon_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_wr = wr_en & (~full | rd_en);
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_rx_mon.sv
// rtl/uart_rx_mon.sv - oversampling UART receive monitor with valid/ready output; UART_RX_MON_FIFO_EN selects a FIFO over a holding register
module uart_rx_mon
    import uart_rx_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] m_data_o,
    output logic                 m_frame_err_o,
    output logic                 m_par_err_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 overflow_o,
    input  logic                 ovf_clr_i,
    output logic                 busy_o
);

    localparam int             CW       = cnt_width(CLKS_PER_BIT);
    localparam int             WW       = DATA_BITS + 2;
    localparam logic [CW-1:0]  CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic           ODD_MODE = (PARITY == PAR_ODD);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_rx_mon: illegal parameter set");
    end

    state_t                state;
    logic                  sync1;
    logic                  rxs;
    logic [CW-1:0]         ccnt;
    logic [3:0]            bcnt;
    logic [DATA_BITS-1:0]  sreg;
    logic                  perr;
    logic                  push;
    logic [WW-1:0]         push_word;
    logic                  pop;
    logic                  full;
    logic [WW-1:0]         head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            ccnt      <= '0;
            bcnt      <= '0;
            sreg      <= '0;
            perr      <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
            busy_o    <= 1'b0;
        end else begin
            sync1  <= rx_i;
            rxs    <= sync1;
            busy_o <= (state != IDLE);
            push   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        bcnt  <= '0;
                        ccnt  <= CNT_HALF;
                        perr  <= 1'b0;
                    end
                end
                START: begin
                    if (ccnt == '0) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (!rxs) begin
                            state <= DATA;
                            ccnt  <= CNT_BIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        ccnt <= ccnt - 1'b1;
                    end
                end
                DATA: begin
                    if (ccnt == '0) begin
                        sreg <= {rxs, sreg[DATA_BITS-1:1]};
                        ccnt <= CNT_BIT;
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == LAST_BIT) begin
                            state <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end
                    end else begin
                        ccnt <= ccnt - 1'b1;
                    end
                end
                PAR: begin
                    if (ccnt == '0) begin
                        perr  <= (^sreg) ^ rxs ^ ODD_MODE;
                        ccnt  <= CNT_BIT;
                        state <= STOP;
                    end else begin
                        ccnt <= ccnt - 1'b1;
                    end
                end
                STOP: begin
                    // Returning to IDLE at mid stop bit lets a following start edge be caught.
                    if (ccnt == '0) begin
                        push      <= 1'b1;
                        push_word <= {sreg, ~rxs, perr};
                        state     <= IDLE;
                    end else begin
                        ccnt <= ccnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop = m_valid_o & m_ready_i;

`ifdef UART_RX_MON_FIFO_EN
    logic empty;

    uart_rx_mon_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (push),
        .wdata (push_word),
        .rd_en (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign m_valid_o = ~empty;
`else
    logic          hold_valid;
    logic [WW-1:0] hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold       <= '0;
        end else if (push && (!hold_valid || pop)) begin
            hold_valid <= 1'b1;
            hold       <= push_word;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign full      = hold_valid;
    assign head      = hold;
    assign m_valid_o = hold_valid;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (push && full && !pop) begin
            overflow_o <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    assign m_data_o      = head[WW-1:2];
    assign m_frame_err_o = head[1];
    assign m_par_err_o   = head[0];

endmodule

// File: tb/tb_uart_rx_mon.sv
// tb/tb_uart_rx_mon.sv - directed table-driven bench for uart_rx_mon (8N1 and 8E1 instances)
`timescale 1ns/1ps
module tb_uart_rx_mon;

    localparam int CPB = 16;
`ifdef UART_RX_MON_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       ferr_a, ferr_b, perr_a, perr_b;
    logic       val_a, val_b, ovf_a, ovf_b, busy_a, busy_b;

    uart_rx_mon #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .m_data_o(data_a), .m_frame_err_o(ferr_a),
        .m_par_err_o(perr_a), .m_valid_o(val_a), .m_ready_i(rdy_a), .overflow_o(ovf_a),
        .ovf_clr_i(clr_a), .busy_o(busy_a)
    );

    uart_rx_mon #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .m_data_o(data_b), .m_frame_err_o(ferr_b),
        .m_par_err_o(perr_b), .m_valid_o(val_b), .m_ready_i(rdy_b), .overflow_o(ovf_b),
        .ovf_clr_i(clr_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge and handshake recorder for dut_a, sampled just before each rising edge.
    logic       pv_a = 1'b0, pb_a = 1'b0;
    int         vrise_a = 0, brise_a = 0, bfall_a = 0, hs_a = 0;
    logic [7:0] last_d_a = 8'h00;
    logic       last_fe_a = 1'b0, last_pe_a = 1'b0;

    always @(negedge clk) begin
        #4;
        if (val_a && !pv_a) vrise_a = cyc;
        if (busy_a && !pb_a) brise_a = cyc;
        if (!busy_a && pb_a) bfall_a = cyc;
        if (val_a && rdy_a) begin
            hs_a++;
            last_d_a  = data_a;
            last_fe_a = ferr_a;
            last_pe_a = perr_a;
        end
        pv_a = val_a;
        pb_a = busy_a;
    end

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         use_par;
        bit         pbit;
        bit         stop;
        bit         ef;
        bit         ep;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit use_par, input bit pbit,
                        input bit stop, output int t0);
        @(negedge clk);
        drive(sel, 1'b0);
        t0 = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (use_par) begin
            drive(sel, pbit);
            repeat (CPB) @(negedge clk);
        end
        drive(sel, stop);
        repeat (CPB) @(negedge clk);
        drive(sel, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_valid(input bit sel);
        int n = 0;
        while (!(sel ? val_b : val_a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("valid_wait", 32'(sel ? val_b : val_a), 32'd1);
    endtask

    task automatic pop(input bit sel);
        if (sel) rdy_b = 1'b1;
        else rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    initial begin
        int t0;
        int hs0;

        vt[0] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(val_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_ferr", 32'(ferr_a), 32'd0);
        check("rst_perr", 32'(perr_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid_b", 32'(val_b), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Latency of a clean 8N1 frame with the consumer always ready.
        rdy_a = 1'b1;
        hs0 = hs_a;
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, t0);
        check("lat_valid_rise", 32'(vrise_a - t0), 32'd155);
        check("lat_busy_rise", 32'(brise_a - t0), 32'd3);
        check("lat_busy_fall", 32'(bfall_a - t0), 32'd155);
        check("lat_words", 32'(hs_a - hs0), 32'd1);
        check("lat_data", 32'(last_d_a), 32'h55);
        check("lat_errs", 32'({last_fe_a, last_pe_a}), 32'd0);

        // Short low pulse on the line must be rejected as a glitch.
        hs0 = hs_a;
        @(negedge clk);
        rx_a = 1'b0;
        t0 = cyc + 1;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_busy_rise", 32'(brise_a - t0), 32'd3);
        check("glitch_words", 32'(hs_a - hs0), 32'd0);
        check("glitch_valid", 32'(val_a), 32'd0);
        check("glitch_busy", 32'(busy_a), 32'd0);
        rdy_a = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send(vt[i].sel, vt[i].d, vt[i].use_par, vt[i].pbit, vt[i].stop, t0);
            wait_valid(vt[i].sel);
            check($sformatf("vec%0d_data", i), 32'(vt[i].sel ? data_b : data_a), 32'(vt[i].d));
            check($sformatf("vec%0d_ferr", i), 32'(vt[i].sel ? ferr_b : ferr_a), 32'(vt[i].ef));
            check($sformatf("vec%0d_perr", i), 32'(vt[i].sel ? perr_b : perr_a), 32'(vt[i].ep));
            pop(vt[i].sel);
            check($sformatf("vec%0d_empty", i), 32'(vt[i].sel ? val_b : val_a), 32'd0);
        end

        // Fill to capacity with no consumer, then one more frame overflows.
        for (int i = 1; i <= CAP; i++) begin
            send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, t0);
        end
        check("fill_no_ovf", 32'(ovf_a), 32'd0);
        check("fill_valid", 32'(val_a), 32'd1);
        send(1'b0, 8'(CAP + 1), 1'b0, 1'b0, 1'b1, t0);
        check("ovf_set", 32'(ovf_a), 32'd1);
        for (int i = 1; i <= CAP; i++) begin
            check($sformatf("drain%0d_data", i), 32'(data_a), 32'(i));
            pop(1'b0);
        end
        check("drain_empty", 32'(val_a), 32'd0);
        check("ovf_sticky", 32'(ovf_a), 32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("ovf_clear", 32'(ovf_a), 32'd0);

        // Reset in the middle of a frame discards the partial word.
        rdy_a = 1'b1;
        hs0 = hs_a;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = i[1];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("midrst_words", 32'(hs_a - hs0), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, t0);
        check("midrst_after_words", 32'(hs_a - hs0), 32'd1);
        check("midrst_after_data", 32'(last_d_a), 32'h5A);
        check("midrst_after_errs", 32'({last_fe_a, last_pe_a}), 32'd0);
        rdy_a = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_mon.md
# uart_rx_mon

Parametrised UART receive monitor, successor to the fixed-rate bench UART decoder. It oversamples a single serial line and reassembles frames, with configurable data width, parity and stop-bit checking. Received words and their error flags go to a valid/ready stream, buffered when configured. It sits on the SoC UART TX pin in simulation benches and in synthesised self-test harnesses, replacing hard-coded baud periods with a cycle-count divider.

## Interface
- CLKS_PER_BIT, 16, clock cycles per bit time; integer ≥ 4
- DATA_BITS, 8, data bits per frame, 5..9, LSB first on line
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- DEPTH, 4, output FIFO entries, power of two ≥ 2 (used only with FIFO macro)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- rx_i  in  1  serial line, idle high, asynchronous to clk
- m_data_o  out  DATA_BITS  received word
- m_frame_err_o  out  1  stop bit sampled low for this word
- m_par_err_o  out  1  parity mismatch for this word (always 0 when PARITY=0)
- m_valid_o  out  1  output word available
- m_ready_i  in  1  consumer accepts word when m_valid_o & m_ready_i
- overflow_o  out  1  sticky: a completed frame was dropped
- ovf_clr_i  in  1  clears overflow_o
- busy_o  out  1  receiver not in IDLE

## Operation
- rx_i passes through a 2-flop synchroniser, reset to 1; all logic uses the synchronised rxs.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: rxs = 0 → START, bit counter bcnt cleared, cycle counter ccnt loaded with H−1, where H = CLKS_PER_BIT/2 (floor).
- START: at ccnt = 0, sample rxs. 0 → DATA with ccnt = CLKS_PER_BIT−1. 1 → IDLE as a glitch; nothing is emitted.
- DATA: at each ccnt = 0, shift rxs into the MSB of the shift register and reload ccnt. After DATA_BITS samples, go to PAR if PARITY≠0, else STOP.
- PAR: one sample. Error if the XOR of data bits and the parity bit is 0 for odd parity, or 1 for even parity.
- STOP: one sample at mid-bit, then push {data, frame_err, par_err} and go directly to IDLE. This allows back-to-back frames with one stop bit.
- Errored frames are still pushed, with their flags set.
- Push while full: the word is discarded and overflow_o is set. ovf_clr_i and a push-overflow in the same cycle leave overflow_o = 1.
- Pop on the m_valid_o & m_ready_i handshake. Push and pop in the same cycle while full is legal: no overflow, count unchanged.
- Reset mid-frame returns to IDLE, empties the buffer and discards the partial word.

## Timing
- Reset values: m_data_o = 0, m_frame_err_o = 0, m_par_err_o = 0, m_valid_o = 0, overflow_o = 0, busy_o = 0; state IDLE; synchroniser flops = 1.
- Latency: let t0 be the first clk edge that samples rx_i = 0, and N = DATA_BITS + (PARITY≠0).
  - rxs falls at t0+2.
  - Start sample at t0+2+H.
  - Data/parity bit k (k = 0..N−1) sampled at t0+2+H+(k+1)·CLKS_PER_BIT.
  - Stop sample at t0+2+H+(N+1)·CLKS_PER_BIT.
  - m_valid_o rises on the following edge when the buffer was empty.
- busy_o is registered and high from t0+3 through the stop-sample cycle.
- m_data_o and the error flags are stable while m_valid_o = 1 and m_ready_i = 0.

## Configuration
- UART_RX_MON_FIFO_EN defined: a DEPTH-entry FIFO holds words of DATA_BITS+2 bits.
- Undefined: a single holding register is used, and DEPTH is ignored. The push-while-full, overflow and same-cycle push/pop rules above are unchanged, with capacity 1.

## Structure
- Package uart_rx_mon_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP)
  - parity mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2
  - a function computing the counter width from CLKS_PER_BIT
- Sub-module uart_rx_mon_fifo is a synchronous FIFO with width and depth parameters and full/empty flags. It is instantiated only under UART_RX_MON_FIFO_EN.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0x55 with m_ready_i=1 → m_data_o=0x55, both errors 0, m_valid_o high exactly at t0+2+8+9·16+1 = t0+155.
- 3-cycle low pulse on rx_i → no word emitted, busy_o returns low, state IDLE.
- 8N1, 0xA3 sent with the stop bit held low → m_data_o=0xA3, m_frame_err_o=1.
- PARITY=2, 0x07 sent with parity bit 0 → m_par_err_o=1; resent with parity bit 1 → m_par_err_o=0.
- FIFO build, DEPTH=4, m_ready_i=0, send 0x01..0x05 → overflow_o=1; reads return 0x01..0x04 in order; ovf_clr_i clears overflow_o.
- rst_n pulsed low for one cycle mid-DATA of frame 0x3C, then 0x5A sent → only 0x5A emitted, no errors.
